// File: rtl/spi_master.sv
// ---------------------------------------------------------------------------
// spi_master
//   Mode-0 SPI master (CPOL=0, CPHA=0), MSB first, one DATA_BIT_WIDTH word
//   per START. SCK is derived from clk by a half-period counter of CLK_DIV
//   cycles. HOLD_SSEL keeps SSEL asserted between words for bursts.
//
// Ports
//   clk        system clock
//   rst        synchronous reset, active-high
//   START      request a word transfer (honoured only in IDLE or WAIT)
//   HOLD_SSEL  keep SSEL low after this word (latched with START)
//   DATA_OUT   word to transmit (latched with START)
//   DATA_IN    last received word, updated in the DONE cycle
//   DONE       one-cycle pulse when a word completes
//   BUSY       high whenever START would be ignored
//   SCK        serial clock, idles low
//   MOSI       serial data out, forced low while SSEL is high
//   MISO       serial data in, asynchronous
//   SSEL       active-low slave select
// ---------------------------------------------------------------------------
module spi_master #(
    parameter int DATA_BIT_WIDTH = 8,
    parameter int CLK_DIV        = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      START,
    input  logic                      HOLD_SSEL,
    input  logic [DATA_BIT_WIDTH-1:0] DATA_OUT,
    output logic [DATA_BIT_WIDTH-1:0] DATA_IN,
    output logic                      DONE,
    output logic                      BUSY,
    output logic                      SCK,
    output logic                      MOSI,
    input  logic                      MISO,
    output logic                      SSEL
);

    localparam int W  = DATA_BIT_WIDTH;
    localparam int BW = $clog2(DATA_BIT_WIDTH) + 1;
    localparam int DW = $clog2(CLK_DIV);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_XFER,
        S_WAIT,
        S_TEARDOWN
    } state_t;

    state_t          state_q;
    state_t          state_nxt;

    logic [DW-1:0]   div_cnt;
    logic [BW-1:0]   bit_cnt;
    logic            hold_q;
    logic [W-2:0]    tx_sh;
    logic [W-2:0]    rx_sh;
    logic            miso_p0;
    logic            miso_p1;

    logic            accept;
    logic            div_last;
    logic            rise_ev;
    logic            fall_ev;
    logic            last_fall;
    logic            word_end;
    logic [W-1:0]    rx_word;

    logic            sck_d;
    logic            ssel_d;
    logic            busy_d;
    logic            mosi_d;
    logic            done_d;
    logic [W-1:0]    data_in_d;

    // ---- event decode --------------------------------------------------
    assign accept    = START && (state_q == S_IDLE || state_q == S_WAIT);
    assign div_last  = (div_cnt == DW'(CLK_DIV - 1));
    // Rising edge ends SETUP, or ends a low phase while bits remain.
    assign rise_ev   = div_last && ((state_q == S_SETUP) ||
                       (state_q == S_XFER && !SCK && bit_cnt < BW'(W)));
    assign fall_ev   = div_last && (state_q == S_XFER) && SCK;
    assign last_fall = fall_ev && (bit_cnt == BW'(W - 1));
    // The cycle after the last falling edge (DONE cycle) closes the word.
    assign word_end  = (state_q == S_XFER) && (bit_cnt == BW'(W));
    // Late sample: MISO is captured on the edge that drives SCK low.
    assign rx_word   = {rx_sh, miso_p1};

    // ---- state register ------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // ---- next-state logic ----------------------------------------------
    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            S_IDLE:     if (START) state_nxt = S_SETUP;
            S_SETUP:    if (div_last) state_nxt = S_XFER;
            S_XFER:     if (word_end) state_nxt = hold_q ? S_WAIT : S_TEARDOWN;
            S_WAIT: begin
                if (START)           state_nxt = S_SETUP;
                else if (!HOLD_SSEL) state_nxt = S_TEARDOWN;
            end
            S_TEARDOWN: if (div_last) state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // ---- output logic (D inputs of the output registers) ---------------
    always_comb begin
        ssel_d = (state_nxt == S_IDLE) || (state_nxt == S_TEARDOWN);
        busy_d = (state_nxt == S_SETUP) || (state_nxt == S_XFER) ||
                 (state_nxt == S_TEARDOWN);

        sck_d = 1'b0;
        if (state_nxt == S_XFER) begin
            if (rise_ev)      sck_d = 1'b1;
            else if (fall_ev) sck_d = 1'b0;
            else              sck_d = SCK;
        end

        mosi_d = MOSI;
        if (accept)                      mosi_d = DATA_OUT[W-1];
        else if (fall_ev && !last_fall)  mosi_d = tx_sh[W-2];
        if (ssel_d)                      mosi_d = 1'b0;

        done_d    = last_fall;
        data_in_d = last_fall ? rx_word : DATA_IN;
    end

    // ---- control and output registers ----------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            SCK     <= 1'b0;
            SSEL    <= 1'b1;
            MOSI    <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            DATA_IN <= '0;
            div_cnt <= '0;
            bit_cnt <= '0;
            hold_q  <= 1'b0;
        end else begin
            SCK     <= sck_d;
            SSEL    <= ssel_d;
            MOSI    <= mosi_d;
            BUSY    <= busy_d;
            DONE    <= done_d;
            DATA_IN <= data_in_d;

            // Phase counter restarts on every state change and every SCK edge.
            if (state_nxt != state_q || div_last) begin
                div_cnt <= '0;
            end else if (state_q == S_SETUP || state_q == S_XFER ||
                         state_q == S_TEARDOWN) begin
                div_cnt <= div_cnt + DW'(1);
            end

            if (accept) begin
                bit_cnt <= '0;
                hold_q  <= HOLD_SSEL;
            end else if (fall_ev) begin
                bit_cnt <= bit_cnt + BW'(1);
            end
        end
    end

    // ---- shift registers and MISO synchroniser (data, no reset) --------
    always_ff @(posedge clk) begin
        miso_p0 <= MISO;
        miso_p1 <= miso_p0;

        if (accept) begin
            tx_sh <= DATA_OUT[W-2:0];
        end else if (fall_ev) begin
            tx_sh <= tx_sh << 1;
        end

        if (fall_ev) begin
            rx_sh <= rx_word[W-2:0];
        end
    end

endmodule

// File: tb/tb_spi_master.sv
module tb_spi_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT 1: defaults (8-bit, CLK_DIV=4)
    logic       rst, START, HOLD_SSEL, MISO, DONE, BUSY, SCK, MOSI, SSEL;
    logic [7:0] DATA_OUT, DATA_IN;

    // DUT 2: 16-bit, CLK_DIV=6, MOSI looped to MISO
    logic        start2, hold2, done2, busy2, sck2, mosi2, ssel2;
    logic [15:0] dout2, din2;

    spi_master dut (
        .clk(clk), .rst(rst), .START(START), .HOLD_SSEL(HOLD_SSEL),
        .DATA_OUT(DATA_OUT), .DATA_IN(DATA_IN), .DONE(DONE), .BUSY(BUSY),
        .SCK(SCK), .MOSI(MOSI), .MISO(MISO), .SSEL(SSEL)
    );

    spi_master #(.DATA_BIT_WIDTH(16), .CLK_DIV(6)) dut2 (
        .clk(clk), .rst(rst), .START(start2), .HOLD_SSEL(hold2),
        .DATA_OUT(dout2), .DATA_IN(din2), .DONE(done2), .BUSY(busy2),
        .SCK(sck2), .MOSI(mosi2), .MISO(mosi2), .SSEL(ssel2)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural mode-0 slave: samples MOSI on SCK rise, advances MISO on SCK fall.
    logic       loopback = 1'b0;
    logic [7:0] slave_tx = 8'h00;
    logic [2:0] bidx = 3'd0;
    logic [7:0] slave_sh = 8'h00;
    int         slave_bits = 0;
    int         rises = 0;
    logic       sck_prev = 1'b0;
    logic [7:0] slave_q[$];
    logic       slave_miso;

    always_comb slave_miso = slave_tx[3'd7 - bidx];
    assign MISO = loopback ? MOSI : slave_miso;

    always @(negedge clk) begin
        if (SSEL) begin
            bidx       <= 3'd0;
            slave_bits <= 0;
        end else begin
            if (SCK && !sck_prev) begin
                slave_sh <= {slave_sh[6:0], MOSI};
                rises    <= rises + 1;
                if (slave_bits == 7) begin
                    slave_q.push_back({slave_sh[6:0], MOSI});
                    slave_bits <= 0;
                end else begin
                    slave_bits <= slave_bits + 1;
                end
            end
            if (!SCK && sck_prev) bidx <= bidx + 3'd1;
        end
        sck_prev <= SCK;
    end

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, o, e);
        end
    endtask

    // SCK is high for cycles [1+cd*(2k+1), 1+cd*(2k+2)) for each bit k.
    function automatic logic exp_sck(input int n, input int w, input int cd);
        for (int k = 0; k < w; k++)
            if (n >= 1 + cd * (2 * k + 1) && n < 1 + cd * (2 * k + 2)) return 1'b1;
        return 1'b0;
    endfunction

    // Bit k is presented for the 8 cycles starting at 1+8k; the LSB then persists.
    function automatic logic exp_mosi(input logic [7:0] w, input int n);
        int k;
        k = (n - 1) / 8;
        if (k > 7) k = 7;
        return w[7 - k];
    endfunction

    // One word on DUT 1, starting at the current negedge (cycle 0).
    task automatic xfer(input logic [7:0] d, input logic hold, input logic [7:0] srx,
                        input bit poke, input logic [7:0] prev_rx, input string tag);
        int         last;
        int         r0;
        int         q0;
        logic [7:0] exp_rx;
        logic       ssel_e, busy_e, mosi_e;
        last   = hold ? 66 : 70;
        r0     = rises;
        q0     = slave_q.size();
        exp_rx = loopback ? d : srx;
        slave_tx  = srx;
        DATA_OUT  = d;
        HOLD_SSEL = hold;
        START     = 1'b1;
        for (int n = 1; n <= last; n++) begin
            @(negedge clk);
            START = poke && (n == 10 || n == 40 || n == 65);
            DATA_OUT  = START ? ~d : d;
            HOLD_SSEL = START ? ~hold : hold;
            ssel_e = !hold && (n >= 66);
            busy_e = hold ? (n <= 65) : (n <= 69);
            mosi_e = (n <= 65 || hold) ? exp_mosi(d, n) : 1'b0;
            chk($sformatf("%s_pins_c%0d", tag, n), 32'({SSEL, SCK, BUSY, DONE, MOSI}),
                32'({ssel_e, exp_sck(n, 8, 4), busy_e, (n == 65), mosi_e}));
            if (n == 64) chk($sformatf("%s_rx_hold", tag), 32'(DATA_IN), 32'(prev_rx));
            if (n == 65) chk($sformatf("%s_rx", tag), 32'(DATA_IN), 32'(exp_rx));
        end
        chk($sformatf("%s_pulses", tag), 32'(rises - r0), 32'd8);
        if (slave_q.size() == q0 + 1)
            chk($sformatf("%s_slave_rx", tag), 32'(slave_q[q0]), 32'(d));
        else
            chk($sformatf("%s_slave_cnt", tag), 32'(slave_q.size()), 32'(q0 + 1));
    endtask

    logic [7:0] last_rx;
    logic [7:0] s;
    logic [7:0] d;
    int         r0;

    initial begin
        rst = 1'b1; START = 1'b0; HOLD_SSEL = 1'b0; DATA_OUT = 8'h00;
        start2 = 1'b0; hold2 = 1'b0; dout2 = 16'h0000;
        repeat (3) @(negedge clk);
        chk("reset_pins", 32'({SCK, SSEL, MOSI, BUSY, DONE, DATA_IN}), 32'({5'b01000, 8'h00}));
        chk("reset_pins2", 32'({sck2, ssel2, mosi2, busy2, done2, din2}), 32'({5'b01000, 16'h0000}));
        rst = 1'b0;
        @(negedge clk);

        // Basic word against the slave model
        xfer(8'hA5, 1'b0, 8'h3C, 1'b0, 8'h00, "basic");
        last_rx = 8'h3C;

        // Loopback
        loopback = 1'b1;
        xfer(8'h00, 1'b0, 8'h00, 1'b0, last_rx, "lb00"); last_rx = 8'h00;
        xfer(8'hFF, 1'b0, 8'h00, 1'b0, last_rx, "lbFF"); last_rx = 8'hFF;
        xfer(8'h81, 1'b0, 8'h00, 1'b0, last_rx, "lb81"); last_rx = 8'h81;
        loopback = 1'b0;

        // Burst under one SSEL assertion
        r0 = rises;
        s = 8'($urandom_range(0, 255));
        xfer(8'h12, 1'b1, s, 1'b0, last_rx, "burst0"); last_rx = s;
        s = 8'($urandom_range(0, 255));
        xfer(8'h34, 1'b1, s, 1'b0, last_rx, "burst1"); last_rx = s;
        s = 8'($urandom_range(0, 255));
        xfer(8'h56, 1'b0, s, 1'b0, last_rx, "burst2"); last_rx = s;
        chk("burst_pulses", 32'(rises - r0), 32'd24);

        // START pulses while busy and in the DONE cycle must be ignored
        s = 8'($urandom_range(0, 255));
        xfer(8'hC3, 1'b0, s, 1'b1, last_rx, "poke"); last_rx = s;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("poke_idle%0d", i), 32'({SSEL, BUSY, SCK}), 32'(3'b100));
        end

        // Reset mid-word
        DATA_OUT = 8'h77; HOLD_SSEL = 1'b0; START = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            START = 1'b0;
            if (n == 30) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_pins", 32'({SCK, SSEL, BUSY, DONE}), 32'(4'b0100));
        chk("midrst_rx", 32'(DATA_IN), 32'h00);
        last_rx = 8'h00;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk($sformatf("midrst_quiet%0d", i), 32'({DONE, SSEL, SCK}), 32'(3'b010));
        end
        s = 8'($urandom_range(0, 255));
        xfer(8'h5A, 1'b0, s, 1'b0, last_rx, "postrst"); last_rx = s;

        // Random words
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom_range(0, 255));
            s = 8'($urandom_range(0, 255));
            xfer(d, 1'b0, s, 1'b0, last_rx, $sformatf("rnd%0d", i));
            last_rx = s;
        end

        // 16-bit, CLK_DIV=6 loopback
        dout2 = 16'hBEEF; start2 = 1'b1;
        for (int n = 1; n <= 194; n++) begin
            @(negedge clk);
            start2 = 1'b0;
            chk($sformatf("w16_c%0d", n), 32'({ssel2, sck2, done2}),
                32'({(n >= 194), exp_sck(n, 16, 6), (n == 193)}));
            if (n == 193) chk("w16_rx", 32'(din2), 32'hBEEF);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
